cpu_mem_responder: RTL

- Memory-side responder for the RISC CPU external bus: decodes the CPU's 13-bit `addr`, services `rd`/`wr` strobes and drives or samples the shared 8-bit `data` bus.
- Holds program ROM at 0x0000–0x17FF and data RAM at 0x1800–0x1FFF, with a configurable number of wait states.
- A side-band load port preloads the ROM before the CPU is released from reset.
- Sits opposite the CPU top level on the board/testbench bus.

---
 rtl/cpu_mem_responder_if.sv | 27 ++
 rtl/cpu_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// CPU external bus bundle between the RISC CPU (master) and the memory
// responder (slave). The shared bidirectional data bus stays a plain port
// on the responder so tristate resolution happens at the module boundary.
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              ready;
  logic              data_oe;
  logic              bus_err;

  modport master (
    output rd, wr, addr, prog_we, prog_addr, prog_data,
    input  ready, data_oe, bus_err
  );

  modport slave (
    input  rd, wr, addr, prog_we, prog_addr, prog_data,
    output ready, data_oe, bus_err
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the RISC CPU bus: program ROM below RAM_BASE,
// data RAM from RAM_BASE to the top of the address space, programmable
// wait states, and a side-band load port for preloading before CPU release.
module cpu_mem_responder #(
  parameter int                WAIT_CYCLES = 1,
  parameter int                ADDR_W      = 13,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] RAM_BASE    = ADDR_W'(13'h1800)
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire   [DATA_W-1:0] data,
  cpu_mem_responder_if.slave bus
);

  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_DONE
  } state_t;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q, ready_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_load;

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  // The output enable is masked by wr so the responder can never fight a
  // CPU write on the shared bus, even for the cycle before the FSM reacts.
  assign bus.data_oe = oe_q & ~bus.wr;
  assign bus.ready   = ready_q;
  assign bus.bus_err = err_q;
  assign data        = bus.data_oe ? rdata_q : {DATA_W{1'bz}};

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
    end
  end

  // Memory array is never cleared; writes are suppressed during reset so a
  // write whose commit edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_load) begin
      rdata_q <= mem[addr_q];
    end
  end

  // Next-state logic: strobe decode, wait-state counting, commit and errors.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ready_d   = ready_q;
    oe_d      = oe_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    rd_load   = 1'b0;

    if (bus.prog_we && (state != IDLE || bus.rd || bus.wr)) begin
      err_d = 1'b1;
    end

    unique case (state)
      IDLE: begin
        ready_d = 1'b0;
        oe_d    = 1'b0;
        if (bus.rd && bus.wr) begin
          err_d = 1'b1;
        end else if (bus.rd) begin
          addr_d  = bus.addr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = RD_WAIT;
        end else if (bus.wr) begin
          addr_d  = bus.addr;
          wdata_d = data;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WR_WAIT;
        end else if (bus.prog_we) begin
          mem_we    = 1'b1;
          mem_waddr = bus.prog_addr;
          mem_wdata = bus.prog_data;
        end
      end

      RD_WAIT: begin
        if (!bus.rd) begin
          state_d = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          rd_load = 1'b1;
          oe_d    = 1'b1;
          ready_d = 1'b1;
          state_d = RD_DRIVE;
        end
      end

      RD_DRIVE: begin
        if (!bus.rd) begin
          oe_d    = 1'b0;
          ready_d = 1'b0;
          state_d = IDLE;
        end else if (bus.addr != addr_q) begin
          oe_d    = 1'b0;
          ready_d = 1'b0;
          addr_d  = bus.addr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = RD_WAIT;
        end
      end

      WR_WAIT: begin
        oe_d = 1'b0;
        if (!bus.wr) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          ready_d = 1'b1;
          state_d = WR_DONE;
          if (addr_q >= RAM_BASE) begin
            mem_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WR_DONE: begin
        oe_d = 1'b0;
        if (!bus.wr) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

endmodule
